// File: rtl/pu_attr_pkg.sv
// Attribute bus definitions shared by the processing units.
// Provides default widths, flag bit indices and an attribute-compose helper.
package pu_attr_pkg;

    localparam int PU_ATTR_WIDTH = 4;
    localparam int PU_INVALID    = 0;
    localparam int PU_LOST       = 1;

    // Builds a wide attribute word with only the invalid and lost flags set.
    // Callers cast the result down to their own ATTR_WIDTH+1 bus.
    function automatic logic [31:0] attr_compose(
        input int   inv_idx,
        input int   lost_idx,
        input logic inv,
        input logic lost
    );
        logic [31:0] a;
        a           = '0;
        a[inv_idx]  = inv;
        a[lost_idx] = lost;
        return a;
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// Signed multiplier followed by STAGES register stages.
// Ports: clk, rst (async, active-low), in_valid/a/b/in_invalid launch an op;
// out_valid/product/out_invalid present it STAGES edges later.
module mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic                      in_invalid,
    output logic                      out_valid,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      out_invalid
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] prod_q [STAGES];
    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    inv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            inv_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            inv_q[0]   <= in_invalid;
            prod_q[0]  <= PW'(a) * PW'(b);
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                inv_q[i]   <= inv_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign out_invalid = inv_q[STAGES-1];
    assign product     = prod_q[STAGES-1];

endmodule

// File: rtl/pu_mult_pipe.sv
// Pipelined fixed-point multiplier PU with saturation and an in-order result FIFO.
// Ports: clk, rst (async, active-low); signal_wr/signal_sel/data_in/attr_in write
// operand A (sel=0) or launch with B (sel=1); signal_oe reads and pops data_out/attr_out.
module pu_mult_pipe
    import pu_attr_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ATTR_WIDTH   = PU_ATTR_WIDTH,
    parameter int FRAC_WIDTH   = 0,
    parameter int MULT_STAGES  = 2,
    parameter int RESULT_DEPTH = 4,
    parameter bit SATURATE     = 1'b1,
    parameter int INVALID      = PU_INVALID,
    parameter int LOST         = PU_LOST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH:0]   attr_in,
    input  logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH:0]   attr_out
);

    localparam int W     = DATA_WIDTH;
    localparam int PW    = 2 * W;
    localparam int PTR_W = $clog2(RESULT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = PTR_W + 2;

    logic [W-1:0]     a_q;
    logic             a_inv_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] flight_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             lost_q;

    logic             launch;
    logic             drop;
    logic             accept;
    logic             push;
    logic             pop;
    logic             empty;
    logic             pipe_inv;
    logic [CRD_W-1:0] credits_used;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic                 ovf;
    logic [W-1:0]         result;

    logic [W-1:0]            mem_data [RESULT_DEPTH];
    logic [RESULT_DEPTH-1:0] mem_inv;
    logic                    head_inv;
    logic [W-1:0]            head_data;
    logic                    unused_attr;

    assign unused_attr = ^attr_in;

    assign launch       = signal_wr & signal_sel;
    assign credits_used = CRD_W'(count_q) + CRD_W'(flight_q);
    assign drop         = launch & (credits_used == CRD_W'(RESULT_DEPTH));
    assign accept       = launch & ~drop;
    assign empty        = (count_q == '0);
    assign pop          = signal_oe & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            a_inv_q <= 1'b0;
        end else if (signal_wr && !signal_sel) begin
            a_q     <= data_in;
            a_inv_q <= attr_in[INVALID];
        end
    end

    mult_pipe #(
        .WIDTH  (W),
        .STAGES (MULT_STAGES)
    ) u_mult (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (accept),
        .a           (a_q),
        .b           (data_in),
        .in_invalid  (a_inv_q | attr_in[INVALID]),
        .out_valid   (push),
        .product     (prod),
        .out_invalid (pipe_inv)
    );

    // Arithmetic shift floors toward -inf; the result fits only when
    // every bit above the new sign bit matches it.
    assign shifted = prod >>> FRAC_WIDTH;
    assign ovf     = ~((&shifted[PW-1:W-1]) | ~(|shifted[PW-1:W-1]));

    always_comb begin
        result = shifted[W-1:0];
        if (ovf && SATURATE) begin
            result = shifted[PW-1] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= result;
            mem_inv[wr_ptr]  <= ovf | pipe_inv;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            flight_q <= '0;
            lost_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            flight_q <= flight_q + CNT_W'(accept) - CNT_W'(push);
            if (drop) begin
                lost_q <= 1'b1;
            end else if (pop) begin
                lost_q <= 1'b0;
            end
        end
    end

    assign head_inv  = empty ? 1'b1 : mem_inv[rd_ptr];
    assign head_data = empty ? '0 : mem_data[rd_ptr];

    assign data_out = signal_oe ? head_data : '0;
    assign attr_out = signal_oe
        ? (ATTR_WIDTH+1)'(attr_compose(INVALID, LOST, head_inv, lost_q))
        : '0;

endmodule

// File: tb/tb_pu_mult_pipe.sv
// Scoreboard bench for pu_mult_pipe in three configurations.
// Launches push expected products; a negedge monitor checks every read.
module tb_pu_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  wr;
    logic [2:0]  oe;
    logic        sel;
    logic [31:0] din;
    logic [4:0]  ain;
    logic [31:0] dout [3];
    logic [4:0]  aout [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        inv;
    } prod_t;

    prod_t prod_q[$];
    logic  lost_q[$];

    always #5 clk = ~clk;

    pu_mult_pipe #(.FRAC_WIDTH(0), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .signal_wr(wr[0]), .signal_sel(sel),
        .data_in(din), .attr_in(ain), .signal_oe(oe[0]),
        .data_out(dout[0]), .attr_out(aout[0])
    );

    pu_mult_pipe #(.FRAC_WIDTH(0), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .signal_wr(wr[1]), .signal_sel(sel),
        .data_in(din), .attr_in(ain), .signal_oe(oe[1]),
        .data_out(dout[1]), .attr_out(aout[1])
    );

    pu_mult_pipe #(.FRAC_WIDTH(16), .SATURATE(1'b1)) u_frac (
        .clk(clk), .rst(rst), .signal_wr(wr[2]), .signal_sel(sel),
        .data_in(din), .attr_in(ain), .signal_oe(oe[2]),
        .data_out(dout[2]), .attr_out(aout[2])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr  = '0;
        oe  = '0;
        sel = 1'b0;
        din = '0;
        ain = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic write_a(input int id, input logic [31:0] v, input logic inv);
        wr[id] = 1'b1;
        sel    = 1'b0;
        din    = v;
        ain    = {4'b0, inv};
        step();
    endtask

    task automatic launch(input int id, input logic [31:0] b, input logic binv,
                          input logic [31:0] exp_d, input logic exp_inv,
                          input logic gone);
        prod_t e;
        wr[id] = 1'b1;
        sel    = 1'b1;
        din    = b;
        ain    = {4'b0, binv};
        if (!gone) begin
            e.data = exp_d;
            e.inv  = exp_inv;
            prod_q.push_back(e);
        end
        step();
    endtask

    task automatic rd(input int id, input logic exp_lost);
        oe[id] = 1'b1;
        lost_q.push_back(exp_lost);
        step();
    endtask

    always @(negedge clk) begin : monitor
        prod_t e;
        logic  el;
        for (int i = 0; i < 3; i++) begin
            if (oe[i]) begin
                if (prod_q.size() > 0) begin
                    e = prod_q.pop_front();
                end else begin
                    e.data = '0;
                    e.inv  = 1'b1;
                end
                el = 1'b0;
                if (lost_q.size() > 0) el = lost_q.pop_front();
                chk($sformatf("u%0d_data", i), dout[i], e.data);
                chk($sformatf("u%0d_attr", i), {27'b0, aout[i]},
                    {27'b0, 3'b000, el, e.inv});
            end
        end
    end

    initial begin
        rst = 1'b0;
        wr  = '0;
        oe  = '0;
        sel = 1'b0;
        din = '0;
        ain = '0;
        #12;
        chk("reset_data", dout[0], 32'h0);
        chk("reset_attr", {27'b0, aout[0]}, 32'h0);
        rst = 1'b1;
        step();

        // basic product then empty read
        write_a(0, 32'd6, 1'b0);
        launch(0, 32'd7, 1'b0, 32'd42, 1'b0, 1'b0);
        idle(2);
        rd(0, 1'b0);
        rd(0, 1'b0);

        // back-to-back launches, A persists
        write_a(0, 32'd2, 1'b0);
        launch(0, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0);
        launch(0, 32'd4, 1'b0, 32'd8, 1'b0, 1'b0);
        launch(0, 32'd5, 1'b0, 32'd10, 1'b0, 1'b0);
        launch(0, 32'd6, 1'b0, 32'd12, 1'b0, 1'b0);
        idle(2);
        repeat (5) rd(0, 1'b0);

        // saturation, A rewritten right after a launch, exact -2^31 fit
        write_a(0, 32'h0001_0000, 1'b0);
        launch(0, 32'h0001_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        write_a(0, 32'hFFFF_0000, 1'b0);
        launch(0, 32'h0001_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        launch(0, 32'h0000_8000, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        write_a(0, 32'hFFFF_FFFD, 1'b0);
        launch(0, 32'd5, 1'b0, 32'hFFFF_FFF1, 1'b0, 1'b0);
        idle(2);
        repeat (5) rd(0, 1'b0);

        // wrap mode
        write_a(1, 32'h0001_0000, 1'b0);
        launch(1, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        idle(2);
        rd(1, 1'b0);
        rd(1, 1'b0);

        // Q16 fraction, operand invalid flags, floor toward -inf
        write_a(2, 32'h0001_8000, 1'b0);
        launch(2, 32'hFFFE_0000, 1'b0, 32'hFFFD_0000, 1'b0, 1'b0);
        write_a(2, 32'h0001_0000, 1'b1);
        launch(2, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b1, 1'b0);
        write_a(2, 32'h0001_0000, 1'b0);
        launch(2, 32'h0002_0000, 1'b1, 32'h0002_0000, 1'b1, 1'b0);
        write_a(2, 32'h0000_0001, 1'b0);
        launch(2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(2);
        repeat (5) rd(2, 1'b0);

        // credit overflow: fifth launch is dropped, lost shows until first pop
        write_a(0, 32'd1, 1'b0);
        launch(0, 32'd10, 1'b0, 32'd10, 1'b0, 1'b0);
        launch(0, 32'd20, 1'b0, 32'd20, 1'b0, 1'b0);
        launch(0, 32'd30, 1'b0, 32'd30, 1'b0, 1'b0);
        launch(0, 32'd40, 1'b0, 32'd40, 1'b0, 1'b0);
        launch(0, 32'd50, 1'b0, 32'd50, 1'b0, 1'b1);
        idle(3);
        rd(0, 1'b1);
        repeat (4) rd(0, 1'b0);

        // reset mid-pipeline discards the op and clears A
        write_a(0, 32'd3, 1'b0);
        launch(0, 32'd3, 1'b0, 32'd9, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #5;
        rst = 1'b1;
        idle(3);
        rd(0, 1'b0);
        launch(0, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0);
        idle(2);
        rd(0, 1'b0);
        write_a(0, 32'd2, 1'b0);
        launch(0, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0);
        idle(2);
        rd(0, 1'b0);
        rd(0, 1'b0);

        idle(2);
        chk("prod_queue_left", prod_q.size(), 32'd0);
        chk("read_queue_left", lost_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_mult_pipe.md
Name: pu_mult_pipe

Overview:
Pipelined, parametrised fixed-point multiplier processing unit, the successor to the single-shot multiplier PU. It sits on the same processing-unit bus: operands are written through signal_wr/signal_sel and results are read through signal_oe. It adds a configurable fraction point, overflow detection with optional saturation, back-to-back issue, and an in-order result FIFO. This allows several products to be queued before the bus reads them.

Parameters:
DATA_WIDTH, 32, operand/result width (signed two's complement)
ATTR_WIDTH, 4, attribute bus is ATTR_WIDTH+1 bits
FRAC_WIDTH, 0, fraction bits; full product is arithmetic-shifted right by this amount
MULT_STAGES, 2, register stages in the multiplier pipeline (>=1)
RESULT_DEPTH, 4, result FIFO entries (power of two, >=2)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (truncate)
INVALID, 0, attr bit index: invalid/overflow flag
LOST, 1, attr bit index: result-dropped flag

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
signal_wr  in  1  operand write strobe
signal_sel  in  1  operand select: 0 = A, 1 = B (launch)
data_in  in  DATA_WIDTH  operand value
attr_in  in  ATTR_WIDTH+1  operand attributes; bit INVALID marks a bad operand
signal_oe  in  1  output enable and FIFO pop
data_out  out  DATA_WIDTH  FIFO head when signal_oe, else 0
attr_out  out  ATTR_WIDTH+1  head attributes when signal_oe, else 0

Behaviour:
- Reset (rst=0, async): A register and A-invalid cleared, pipeline valid bits cleared, FIFO pointers and count set to 0, lost flag cleared. Outputs are 0 because they are gated by signal_oe and the FIFO is empty. In-flight operations are discarded.
- Write with sel=0: latch A and attr_in[INVALID]. A persists across launches until it is rewritten.
- Write with sel=1 is a launch. The latched A and the incoming data_in (not registered) enter stage 0 with their invalid flags at the same edge.
- Launch edge is e0. The result is pushed into the FIFO at edge e0+MULT_STAGES and is readable in the following cycle. One launch per cycle is sustained.
- Arithmetic: full signed 2*DATA_WIDTH product P. Compute R = P >>> FRAC_WIDTH, which truncates toward -inf. Overflow is set if R does not fit in signed DATA_WIDTH.
  - With SATURATE=1, overflow yields 2^(W-1)-1 for positive P and -2^(W-1) for negative P.
  - With SATURATE=0, overflow yields the low DATA_WIDTH bits.
- Stored invalid = overflow | A-invalid | B-invalid.
- Credit check: at launch, if FIFO count plus in-flight ops equals RESULT_DEPTH, the op is dropped. The sticky lost flag is set, and nothing enters the pipeline.
- Read: while signal_oe=1 and the FIFO is non-empty:
  - data_out is the head data.
  - attr_out[INVALID] is the head invalid bit.
  - attr_out[LOST] is the lost flag.
  - All other attr bits are 0.
  - The head pops at the clock edge, so one pop occurs per signal_oe cycle.
  - The lost flag clears on the same pop edge unless a new drop occurs on that edge; a new drop takes priority.
- Read while empty: data_out=0, attr_out[INVALID]=1, attr_out[LOST]=lost flag. There is no pop and no pointer change.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full with a pop on the same edge, the push is accepted; this is guaranteed by the credit check.
- Pointers wrap modulo RESULT_DEPTH.
- Simultaneous sel=0 write and launch is impossible (single select). An A-write in the cycle after a launch does not affect the launched op.

Decomposition:
- Shared package/header pu_attr_pkg: ATTR_WIDTH, INVALID and LOST bit indices, and an attribute-compose helper reused by all PUs.
- Sub-module mult_pipe: signed multiplier plus MULT_STAGES registers, carrying valid and invalid bits alongside the data.
- Shift/saturate logic, credit counter and FIFO stay in the top level.

Test Plan:
1. W=32, FRAC=0, STAGES=2. Write A=6, then launch B=7 at edge e0, then oe from e0+3 -> data_out=42, attr=0; the next oe returns 0 with INVALID=1.
2. A=2, launch B=3,4,5,6 on consecutive cycles, then oe for 4 cycles -> 6, 8, 10, 12 in order, INVALID=0, FIFO empty afterwards.
3. SATURATE=1: A=0x00010000 * B=0x00010000 -> 0x7FFFFFFF with INVALID=1; A=0xFFFF0000 * B=0x00010000 -> 0x80000000 with INVALID=1. With SATURATE=0, the same first pair -> 0x00000000 with INVALID=1.
4. FRAC=16: A=0x00018000 (1.5) * B=0xFFFE0000 (-2.0) -> 0xFFFD0000 (-3.0), INVALID=0. An operand written with attr_in[INVALID]=1 -> result INVALID=1.
5. DEPTH=4: 5 launches with no reads -> reads return the first 4 products in order. LOST=1 on each read until the first pop edge; the subsequent read shows LOST=0.
6. Launch A=3 * B=3, assert rst=0 for half a cycle mid-pipeline, then release and read -> FIFO empty (data_out=0). A new A=2 * B=2 then returns 4.
